fifo_drain_framer: RTL and testbench
====================================

Name: fifo_drain_framer

Overview:
Read-side consumer for the 16-bit dual-clock sample FIFO. It runs entirely in the FIFO read clock domain and drains the FIFO read port (rdreq/q/rdempty/rdusedw). It emits fixed-length frames, each one header word followed by PKT_LEN payload words, on a valid/ready stream towards the host-interface writer. A small prefetch buffer hides the FIFO's one-cycle read latency, so sustained throughput is one word per clock.

Parameters:
WIDTH, 16, FIFO and stream word width
PKT_LEN, 8, payload words per frame (1..12, at most FIFO depth)
USEDW_BITS, 4, width of FIFO rdusedw
HDR_TAG, 4'hA, constant placed in header bits [15:12]

Ports:
rdclk  in  1  FIFO read clock; the only clock
aclr_n  in  1  asynchronous active-low reset
enable  in  1  permit new frames; sampled only in IDLE
rdreq  out  1  FIFO read request
q  in  WIDTH  FIFO read data, valid the cycle after rdreq
rdempty  in  1  FIFO empty (read domain)
rdusedw  in  USEDW_BITS  FIFO fill level (read domain)
out_data  out  WIDTH  stream word
out_valid  out  1  stream word valid
out_ready  in  1  downstream accepts when out_valid and out_ready are both high
out_sop  out  1  marks the header word
out_eop  out  1  marks the last payload word
busy  out  1  high in any state other than IDLE
seq  out  12  sequence number of the next or current frame

Behaviour:
- Reset: one clock (rdclk); aclr_n is asynchronous and active-low. While low, every output is 0, seq=0, state=IDLE, buffer empty, counters 0.
- States: IDLE, HEADER, PAYLOAD.
- IDLE -> HEADER when enable=1, rdusedw>=PKT_LEN and rdempty=0, all sampled on the same edge.
- HEADER: out_valid=1, out_sop=1, out_data={HDR_TAG,seq}. On acceptance the block moves to PAYLOAD. Header valid appears the cycle after the IDLE condition is met.
- PAYLOAD: the block presents buffered FIFO words. On acceptance of payload word PKT_LEN, out_eop=1 on that word, the block returns to IDLE, and seq increments (modulo 4096, so 4095 wraps to 0).
- Prefetch buffer: 2 entries, plus an in-flight flag for the read issued last cycle.
- rdreq rule: rdreq=1 iff state is HEADER or PAYLOAD, reads_issued<PKT_LEN, rdempty=0, and (occupancy + inflight) < 2, where occupancy is measured after this cycle's pop. Prefetch therefore starts during HEADER.
- The word returned on q is written into the buffer on the cycle after rdreq.
- The stream never presents a payload word in HEADER. out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- rdreq is never asserted while rdempty=1, so the block cannot underflow the FIFO.
- If rdempty rises mid-frame despite the entry check, out_valid drops and the frame stalls until data arrives. No words are dropped or duplicated.
- enable deasserted mid-frame: the current frame completes; the block then idles.
- Back-to-back frames: IDLE is held at least 1 cycle between frames, so the rdusedw check is re-evaluated.
- reads_issued and words_sent are counters of width clog2(PKT_LEN+1). Both clear on entry to HEADER.
- Reset asserted mid-frame: immediate abort, buffer discarded, seq=0. The FIFO is reset by the same system reset, so no partial frame data survives.

Decomposition:
- Shared package/include: state encodings (IDLE=0, HEADER=1, PAYLOAD=2), HDR_TAG default, SEQ_BITS=12.
- One natural sub-module, stream_skid2: the 2-entry prefetch/skid buffer. It has a push port (data plus push) and a valid/ready pop port, and exposes its occupancy.
- The FSM, counters and rdreq logic live in the top module.

Test Plan:
- Reset, then FIFO preloaded with 8 words 0x0001..0x0008, enable=1, out_ready=1 -> header 0xA000 with sop, then 0x0001..0x0008 on 8 consecutive cycles with eop on 0x0008; seq becomes 1; exactly 8 rdreq pulses.
- FIFO holds 7 words, enable=1 -> stays IDLE, rdreq=0, out_valid=0. Push an 8th word -> frame starts.
- Same frame with out_ready toggled 1,0,0,1,... -> out_data held stable while stalled; order preserved; rdreq never makes (occupancy + inflight) exceed 2.
- seq preset to 4095 via 4095 frames (or a force) -> header 0xAFFF, the next header is 0xA000.
- enable dropped during payload word 3 -> the frame finishes with eop; no next header while enable=0.
- aclr_n pulsed low during payload word 5 -> all outputs 0 asynchronously, seq=0. After release with FIFO refilled to 8 words, a complete frame is produced with header 0xA000.

Source files
------------

// File: rtl/fifo_drain_framer_pkg.sv
// fifo_drain_framer_pkg: state encodings and shared constants for the FIFO drain framer.
package fifo_drain_framer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    localparam logic [3:0] HDR_TAG_DEF = 4'hA;
    localparam int SEQ_BITS = 12;

endpackage

// File: rtl/fifo_drain_framer_stream_skid2.sv
// stream_skid2: two-entry buffer with a push port and a valid/ready pop port.
module stream_skid2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       occupancy
);
    logic [WIDTH-1:0] mem [2];
    logic rd_ptr, wr_ptr, pop;

    assign pop_valid = occupancy != 2'd0;
    assign pop       = pop_valid && pop_ready;
    assign pop_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // The caller never pushes into a full buffer, so no overflow guard here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (push) wr_ptr <= !wr_ptr;
            if (pop) rd_ptr <= !rd_ptr;
            occupancy <= occupancy + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/fifo_drain_framer.sv
// fifo_drain_framer: drains the sample FIFO read port into fixed-length frames
// (one header word + PKT_LEN payload words) on a valid/ready stream.
module fifo_drain_framer
    import fifo_drain_framer_pkg::*;
#(
    parameter int         WIDTH      = 16,
    parameter int         PKT_LEN    = 8,
    parameter int         USEDW_BITS = 4,
    parameter logic [3:0] HDR_TAG    = HDR_TAG_DEF
) (
    input  logic                  rdclk,
    input  logic                  aclr_n,
    input  logic                  enable,
    output logic                  rdreq,
    input  logic [WIDTH-1:0]      q,
    input  logic                  rdempty,
    input  logic [USEDW_BITS-1:0] rdusedw,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  busy,
    output logic [SEQ_BITS-1:0]   seq
);
    localparam int CW = $clog2(PKT_LEN + 1);
    localparam logic [CW-1:0] LEN = CW'(PKT_LEN);
    localparam logic [USEDW_BITS-1:0] NEED = USEDW_BITS'(PKT_LEN);

    state_t state;
    logic [CW-1:0] reads_issued, words_sent;
    logic inflight, head_valid, drain, pop;
    logic [WIDTH-1:0] head;
    logic [1:0] occupancy;

    assign drain = state == PAYLOAD && out_ready;
    assign pop   = drain && head_valid;

    stream_skid2 #(.WIDTH(WIDTH)) u_skid (
        .clk       (rdclk),
        .rst_n     (aclr_n),
        .push      (inflight),
        .push_data (q),
        .pop_valid (head_valid),
        .pop_ready (drain),
        .pop_data  (head),
        .occupancy (occupancy)
    );

    // The read issued last cycle still needs a slot, so count it against capacity.
    assign rdreq = state != IDLE && reads_issued < LEN && !rdempty
                   && (occupancy - 2'(pop)) + 2'(inflight) < 2'd2;

    assign busy      = state != IDLE;
    assign out_sop   = state == HEADER;
    assign out_valid = out_sop || (state == PAYLOAD && head_valid);
    assign out_eop   = state == PAYLOAD && head_valid && words_sent == LEN - CW'(1);
    assign out_data  = out_sop ? WIDTH'({HDR_TAG, seq})
                     : (state == PAYLOAD && head_valid) ? head : '0;

    always_ff @(posedge rdclk or negedge aclr_n) begin
        if (!aclr_n) begin
            state        <= IDLE;
            seq          <= '0;
            reads_issued <= '0;
            words_sent   <= '0;
            inflight     <= 1'b0;
        end else begin
            inflight <= rdreq;
            if (rdreq) reads_issued <= reads_issued + CW'(1);
            case (state)
                IDLE: if (enable && rdusedw >= NEED && !rdempty) begin
                    state        <= HEADER;
                    reads_issued <= '0;
                    words_sent   <= '0;
                end
                HEADER: if (out_ready) state <= PAYLOAD;
                PAYLOAD: if (pop) begin
                    words_sent <= words_sent + CW'(1);
                    if (out_eop) begin
                        state <= IDLE;
                        seq   <= seq + SEQ_BITS'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_framer.sv
// tb_fifo_drain_framer: table vectors, directed corner sequences and random traffic
// checked against a frame-level model fed by a queue-based FIFO.
module tb_fifo_drain_framer;
    localparam int W = 16;
    localparam int L = 8;

    logic rdclk = 1'b0, aclr_n = 1'b0, enable = 1'b0, out_ready = 1'b0, rdempty = 1'b1;
    logic rdreq, out_valid, out_sop, out_eop, busy;
    logic [W-1:0] q = '0, out_data;
    logic [3:0] rdusedw = '0;
    logic [11:0] seq;

    fifo_drain_framer dut (
        .rdclk(rdclk), .aclr_n(aclr_n), .enable(enable), .rdreq(rdreq), .q(q),
        .rdempty(rdempty), .rdusedw(rdusedw), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .seq(seq)
    );

    always #5 rdclk = ~rdclk;

    typedef struct packed {logic [W-1:0] d; logic sop; logic eop;} word_t;
    typedef struct {int preload; bit en; bit [7:0] pat; int frames;} vec_t;

    logic [W-1:0] fifo[$];
    word_t exp_q[$];
    int errors = 0, checks = 0;
    int mseq, reads, pays, frames, rd_total, cyc, first_pay, last_pay;
    bit mbusy, pv, pr;
    logic [W-1:0] pd, hdr_prev, hdr_last;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic sync_flags();
        rdempty = fifo.size() == 0;
        rdusedw = fifo.size() > 15 ? 4'd15 : 4'(fifo.size());
    endtask

    task automatic push(logic [W-1:0] d);
        fifo.push_back(d);
        sync_flags();
    endtask

    // One clock: sample away from the edge, update the model, then advance the FIFO.
    task automatic cycle();
        bit r, acc, start;
        word_t e;
        #1;
        cyc++;
        r = rdreq;
        acc = out_valid && out_ready;
        start = !mbusy && enable && fifo.size() >= L;
        chk("busy", busy, mbusy);
        if (!mbusy) chk("idle_valid", out_valid, 0);
        if (pv && !pr) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, pd);
        end
        if (r) chk("rdreq_nonempty", fifo.size() > 0, 1);
        reads += r;
        rd_total += r;
        if (acc) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word: got %0h with nothing expected", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("data", out_data, e.d);
                chk("sop", out_sop, e.sop);
                chk("eop", out_eop, e.eop);
                if (e.sop) begin
                    hdr_prev = hdr_last;
                    hdr_last = out_data;
                end else begin
                    pays++;
                    if (pays == 1) first_pay = cyc;
                end
                if (e.eop) begin
                    last_pay = cyc;
                    chk("reads_per_frame", reads, L);
                    mbusy = 0;
                    mseq = (mseq + 1) % 4096;
                    frames++;
                end
            end
        end
        if (mbusy) chk("outstanding_le2", (reads - pays) <= 2, 1);
        if (start) begin
            mbusy = 1;
            reads = 0;
            pays = 0;
            exp_q.push_back('{d: {4'hA, 12'(mseq)}, sop: 1'b1, eop: 1'b0});
            for (int i = 0; i < L; i++) exp_q.push_back('{d: fifo[i], sop: 1'b0, eop: i == L - 1});
        end
        pv = out_valid;
        pr = out_ready;
        pd = out_data;
        @(posedge rdclk);
        #1;
        if (r && fifo.size() > 0) q = fifo.pop_front();
        sync_flags();
        @(negedge rdclk);
    endtask

    // Asserting reset also clears the FIFO, which shares the system reset.
    task automatic do_reset();
        aclr_n = 0;
        enable = 0;
        out_ready = 0;
        fifo.delete();
        exp_q.delete();
        mbusy = 0;
        mseq = 0;
        pv = 0;
        reads = 0;
        pays = 0;
        sync_flags();
        #1;
        chk("reset_outs", {rdreq, out_valid, out_sop, out_eop, busy, out_data}, 0);
        chk("reset_seq", seq, 0);
        repeat (2) @(negedge rdclk);
        aclr_n = 1;
        frames = 0;
        rd_total = 0;
    endtask

    task automatic run(int n, bit [7:0] pat);
        for (int i = 0; i < n; i++) begin
            out_ready = pat[i % 8];
            cycle();
        end
    endtask

    task automatic until_pays(int k, int limit);
        int n = 0;
        while (!(mbusy && pays >= k) && n < limit) begin
            cycle();
            n++;
        end
        chk("pays_reached", mbusy && pays >= k, 1);
    endtask

    task automatic until_frames(int k, int limit);
        int n = 0;
        while (frames < k && n < limit) begin
            cycle();
            n++;
        end
        chk("frames_reached", frames >= k, 1);
    endtask

    initial begin
        vec_t vecs[6];
        vecs = '{
            '{8,  1'b1, 8'hFF, 1},
            '{7,  1'b1, 8'hFF, 0},
            '{8,  1'b0, 8'hFF, 0},
            '{15, 1'b1, 8'h99, 1},
            '{12, 1'b1, 8'h55, 1},
            '{9,  1'b1, 8'b1001_0011, 1}
        };

        foreach (vecs[k]) begin
            do_reset();
            for (int i = 0; i < vecs[k].preload; i++) push(W'($urandom));
            enable = vecs[k].en;
            run(80, vecs[k].pat);
            chk("vec_frames", frames, vecs[k].frames);
            chk("vec_fifo_left", fifo.size(), vecs[k].preload - L * vecs[k].frames);
        end

        // First frame from a known FIFO image.
        do_reset();
        for (int i = 1; i <= 8; i++) push(W'(i));
        enable = 1;
        run(30, 8'hFF);
        chk("first_header", hdr_last, 16'hA000);
        chk("first_frames", frames, 1);
        chk("first_seq", seq, 1);
        chk("first_rdreqs", rd_total, 8);
        chk("payload_burst", last_pay - first_pay, 7);

        // Seven words are not enough; the eighth starts the frame.
        do_reset();
        for (int i = 0; i < 7; i++) push(W'($urandom));
        enable = 1;
        run(20, 8'hFF);
        chk("seven_idle", busy, 0);
        chk("seven_rdreqs", rd_total, 0);
        push(W'($urandom));
        run(30, 8'hFF);
        chk("eighth_frames", frames, 1);

        // Random traffic with backpressure and occasional enable toggles.
        do_reset();
        enable = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo.size() < 15) push(W'($urandom));
            if ($urandom_range(0, 63) == 0) enable = !enable;
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        chk("random_progress", frames > 5, 1);

        // Sequence number wrap: frame 4095 then frame 0.
        do_reset();
        enable = 1;
        out_ready = 1;
        for (int n = 0; frames < 4097 && n < 60000; n++) begin
            if (fifo.size() < 15) push(W'($urandom));
            cycle();
        end
        chk("wrap_frames", frames, 4097);
        chk("wrap_hdr_fff", hdr_prev, 16'hAFFF);
        chk("wrap_hdr_000", hdr_last, 16'hA000);

        // Enable dropped mid-payload: frame completes, no new frame.
        do_reset();
        for (int i = 0; i < 15; i++) push(W'($urandom));
        enable = 1;
        out_ready = 1;
        until_pays(3, 50);
        enable = 0;
        run(40, 8'hFF);
        chk("endrop_frames", frames, 1);
        chk("endrop_idle", busy, 0);
        chk("endrop_left", fifo.size(), 7);

        // Reset mid-frame after one completed frame (seq = 1).
        do_reset();
        for (int i = 0; i < 8; i++) push(W'($urandom));
        enable = 1;
        out_ready = 1;
        until_frames(1, 50);
        for (int i = 0; i < 8; i++) push(W'($urandom));
        until_pays(4, 50);
        chk("pre_reset_seq", seq, 1);
        #2;
        do_reset();
        for (int i = 0; i < 8; i++) push(W'($urandom));
        enable = 1;
        run(30, 8'hFF);
        chk("post_reset_frames", frames, 1);
        chk("post_reset_header", hdr_last, 16'hA000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
